alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised successor to the single-cycle add/sub ALU with its flags register.
- Adds logic ops, carry-chained ADC/SBC, and multi-cycle shifts and unsigned multiply under a START/BUSY/DONE handshake.
- Adds a four-flag register (Z, C, N, V).
- Sits between the A/B registers and the shared CPU data bus; drives the bus tri-state only when enabled.

Parameters:
- DATA_WIDTH, 8, operand/result width (≥4); shift amount uses low $clog2(DATA_WIDTH) bits of B.
- ENABLE_MUL, 1, 0 turns MUL into a reserved opcode.

Ports:
- i_CLOCK  input  1  rising-edge clock
- i_CLEAR_N  input  1  synchronous active-low reset
- i_A_DATA  input  DATA_WIDTH  operand A
- i_B_DATA  input  DATA_WIDTH  operand B / shift amount
- i_OP  input  4  opcode, latched at START
- i_START  input  1  begin operation; sampled only in IDLE
- i_UPDATE_FLAGS  input  1  latched at START; flags written at completion only if set
- i_WRITE_BUS  input  1  high drives o_BUS, else high-Z
- o_BUS  output  DATA_WIDTH  tri-state result low half
- o_RESULT_HI  output  DATA_WIDTH  MUL high half; 0 for all other ops
- o_BUSY  output  1  high in SHIFT/MUL states
- o_DONE  output  1  one-cycle completion pulse
- o_ZERO_FLAG, o_CARRY_FLAG, o_NEGATIVE_FLAG, o_OVERFLOW_FLAG  output  1 each  registered flags

Behaviour:
- Reset (i_CLEAR_N low at edge): state IDLE; result lo/hi = 0; all flags = 0; o_BUSY = 0; o_DONE = 0.
  - Reset aborts any in-flight op; no DONE and no flag write.
  - Reset has priority over START.
- Opcodes:
  - 0 ADD, 1 SUB (A−B), 2 ADC (A+B+C), 3 SBC (A−B−C)
  - 4 AND, 5 OR, 6 XOR, 7 NOT A
  - 8 SHL, 9 SHR (logical), 10 SAR
  - 11 MUL (unsigned)
  - 12–15 reserved: result 0, Z=1, C=N=V=0.
- Operand latching: A, B, OP, UPDATE_FLAGS and the current C (for ADC/SBC) are captured at the START edge. Later input changes do not affect the op.
- States: IDLE, SHIFT, MUL.
- Single-cycle ops (0–7, reserved, and shifts with amount 0):
  - START in IDLE → result registered at the same edge.
  - o_DONE high the following cycle; stays IDLE.
- Shifts (amount n>0):
  - IDLE→SHIFT; one bit per cycle; o_BUSY high n cycles.
  - Result and DONE appear n+1 cycles after START, then back to IDLE.
  - Amount 0 means result = A, C = 0.
- MUL: IDLE→MUL, shift-add one bit per cycle, DATA_WIDTH iterations; DONE at cycle DATA_WIDTH+1; back to IDLE.
- Result register updates only at completion. The bus shows the previous result while busy.
- START while BUSY or in the DONE cycle of a multi-cycle op (already back in IDLE) is handled as follows:
  - While BUSY: ignored.
  - In IDLE with DONE high: accepted, giving back-to-back ops.
- Flags (written at completion when latched UPDATE_FLAGS=1, otherwise held):
  - Z: result low half == 0 (MUL: full 2W product == 0).
  - N: result msb (MUL: product msb).
  - C:
    - ADD/ADC: carry out of bit DATA_WIDTH−1.
    - SUB/SBC: borrow (1 when A < B + Cin, unsigned).
    - Shifts: last bit shifted out.
    - MUL: hi ≠ 0.
    - Logic ops: 0.
  - V:
    - ADD/ADC/SUB/SBC: two's-complement signed overflow.
    - MUL: hi ≠ 0.
    - Other ops: 0.
- Arithmetic is modulo 2^DATA_WIDTH; carries are computed at DATA_WIDTH+1 bits.

Test Plan:
- ADD 0xF0+0x20, UPDATE=1 → DONE 1 cycle after START; o_BUS=0x10 with WRITE_BUS=1; C=1, Z=0, N=0, V=0. WRITE_BUS=0 → o_BUS high-Z.
- SUB 0x05−0x05 → 0x00, Z=1, C=0. Then SUB 0x03−0x05 → 0xFE, C=1, N=1. Then SBC 0x10−0x01 with C=1 → 0x0E, C=0.
- ADD 0x7F+0x01 → 0x80, V=1, N=1, C=0. Then AND 0xF0&0x3C with UPDATE=0 → 0x30, flags unchanged (V=1, N=1).
- SHL A=0x81 B=3:
  - o_BUSY high 3 cycles, DONE at cycle 4, result 0x08, C=0.
  - START pulsed mid-shift is ignored.
  - SAR A=0x80 B=2 → 0xE0, N=1.
- MUL 0x10×0x20 → DONE at cycle 9, o_BUS=0x00, o_RESULT_HI=0x02, Z=0, C=V=1. MUL 0xFF×0xFF → lo 0x01, hi 0xFE.
- Reset mid-op and reserved opcode:
  - Start MUL; assert i_CLEAR_N low at cycle 4 → next cycle BUSY=0, result 0, all flags 0, no DONE.
  - Op 13 after reset → result 0, Z=1.

Source files
------------

// File: rtl/alu_seq.sv
// Sequential ALU with a Z/C/N/V flag register and a tri-state bus driver.
// Logic and add/sub ops finish in one cycle; shifts and multiply iterate one bit per cycle.
module alu_seq #(
  parameter int DATA_WIDTH = 8,
  parameter bit ENABLE_MUL = 1'b1
) (
  input  logic                  i_CLOCK,
  input  logic                  i_CLEAR_N,
  input  logic [DATA_WIDTH-1:0] i_A_DATA,
  input  logic [DATA_WIDTH-1:0] i_B_DATA,
  input  logic [3:0]            i_OP,
  input  logic                  i_START,
  input  logic                  i_UPDATE_FLAGS,
  input  logic                  i_WRITE_BUS,
  output logic [DATA_WIDTH-1:0] o_BUS,
  output logic [DATA_WIDTH-1:0] o_RESULT_HI,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic                  o_ZERO_FLAG,
  output logic                  o_CARRY_FLAG,
  output logic                  o_NEGATIVE_FLAG,
  output logic                  o_OVERFLOW_FLAG
);

  localparam int W  = DATA_WIDTH;
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [SW:0] MUL_CNT = (SW+1)'(W);

  typedef enum logic [1:0] {IDLE, SHIFT, MUL} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  lo_q, lo_d, hi_q, hi_d, mcand_q, mcand_d;
  logic [2*W-1:0] work_q, work_d;
  logic [SW:0]   cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic          upd_q, upd_d, done_q, done_d;
  logic          z_q, z_d, c_q, c_d, n_q, n_d, v_q, v_d;

  logic [W:0]    sum_w;
  logic [W-1:0]  r, sh_cur, sh_next;
  logic          fc, fv, sh_out;
  logic [W:0]    mul_t;
  logic [2*W-1:0] prod_next;
  logic [SW-1:0] amt;
  logic          is_shift;

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    mcand_d = mcand_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    upd_d   = upd_q;
    done_d  = 1'b0;
    z_d     = z_q;
    c_d     = c_q;
    n_d     = n_q;
    v_d     = v_q;

    amt      = i_B_DATA[SW-1:0];
    is_shift = (i_OP == 4'd8) || (i_OP == 4'd9) || (i_OP == 4'd10);

    // Single-cycle datapath, fed straight from the live inputs at the START edge
    sum_w = '0;
    r     = '0;
    fc    = 1'b0;
    fv    = 1'b0;
    case (i_OP)
      4'd0, 4'd2: begin
        sum_w = {1'b0, i_A_DATA} + {1'b0, i_B_DATA}
              + {{W{1'b0}}, (i_OP == 4'd2) & c_q};
        r  = sum_w[W-1:0];
        fc = sum_w[W];
        fv = (i_A_DATA[W-1] == i_B_DATA[W-1]) && (r[W-1] != i_A_DATA[W-1]);
      end
      4'd1, 4'd3: begin
        sum_w = {1'b0, i_A_DATA} - {1'b0, i_B_DATA}
              - {{W{1'b0}}, (i_OP == 4'd3) & c_q};
        r  = sum_w[W-1:0];
        fc = sum_w[W];
        fv = (i_A_DATA[W-1] != i_B_DATA[W-1]) && (r[W-1] != i_A_DATA[W-1]);
      end
      4'd4:                r = i_A_DATA & i_B_DATA;
      4'd5:                r = i_A_DATA | i_B_DATA;
      4'd6:                r = i_A_DATA ^ i_B_DATA;
      4'd7:                r = ~i_A_DATA;
      4'd8, 4'd9, 4'd10:   r = i_A_DATA;
      default:             r = '0;
    endcase

    sh_cur  = work_q[W-1:0];
    sh_next = '0;
    sh_out  = 1'b0;
    case (op_q)
      4'd8:    begin sh_next = {sh_cur[W-2:0], 1'b0};       sh_out = sh_cur[W-1]; end
      4'd9:    begin sh_next = {1'b0, sh_cur[W-1:1]};       sh_out = sh_cur[0];   end
      default: begin sh_next = {sh_cur[W-1], sh_cur[W-1:1]}; sh_out = sh_cur[0];   end
    endcase

    // Shift-add step: upper half accumulates, lower half holds the remaining multiplier bits
    mul_t     = {1'b0, work_q[2*W-1:W]} + (work_q[0] ? {1'b0, mcand_q} : '0);
    prod_next = {mul_t, work_q[W-1:1]};

    case (state_q)
      IDLE: begin
        if (i_START) begin
          op_d  = i_OP;
          upd_d = i_UPDATE_FLAGS;
          if (is_shift && (amt != '0)) begin
            state_d = SHIFT;
            work_d  = {{W{1'b0}}, i_A_DATA};
            cnt_d   = {1'b0, amt};
          end else if (ENABLE_MUL && (i_OP == 4'd11)) begin
            state_d = MUL;
            work_d  = {{W{1'b0}}, i_B_DATA};
            mcand_d = i_A_DATA;
            cnt_d   = MUL_CNT;
          end else begin
            lo_d   = r;
            hi_d   = '0;
            done_d = 1'b1;
            if (i_UPDATE_FLAGS) begin
              z_d = (r == '0);
              c_d = fc;
              n_d = r[W-1];
              v_d = fv;
            end
          end
        end
      end
      SHIFT: begin
        work_d = {{W{1'b0}}, sh_next};
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          state_d = IDLE;
          lo_d    = sh_next;
          hi_d    = '0;
          done_d  = 1'b1;
          if (upd_q) begin
            z_d = (sh_next == '0);
            c_d = sh_out;
            n_d = sh_next[W-1];
            v_d = 1'b0;
          end
        end
      end
      MUL: begin
        work_d = prod_next;
        cnt_d  = cnt_q - 1'b1;
        if (cnt_q == 1) begin
          state_d = IDLE;
          lo_d    = prod_next[W-1:0];
          hi_d    = prod_next[2*W-1:W];
          done_d  = 1'b1;
          if (upd_q) begin
            z_d = (prod_next == '0);
            c_d = |prod_next[2*W-1:W];
            n_d = prod_next[2*W-1];
            v_d = |prod_next[2*W-1:W];
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_CLOCK) begin
    if (!i_CLEAR_N) begin
      state_q <= IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      mcand_q <= '0;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
      n_q     <= 1'b0;
      v_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      mcand_q <= mcand_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
      z_q     <= z_d;
      c_q     <= c_d;
      n_q     <= n_d;
      v_q     <= v_d;
    end
  end

  assign o_BUS           = i_WRITE_BUS ? lo_q : 'z;
  assign o_RESULT_HI     = hi_q;
  assign o_BUSY          = (state_q != IDLE);
  assign o_DONE          = done_q;
  assign o_ZERO_FLAG     = z_q;
  assign o_CARRY_FLAG    = c_q;
  assign o_NEGATIVE_FLAG = n_q;
  assign o_OVERFLOW_FLAG = v_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: vector table for every opcode plus hand-written
// sequences for bus release, ignored/back-to-back START, reset abort and reserved ops.
module tb_alu_seq;

  logic       clock = 1'b0;
  logic       clear_n;
  logic [7:0] a_data, b_data;
  logic [3:0] op;
  logic       start, update_flags, write_bus;
  wire  [7:0] bus;
  logic [7:0] result_hi;
  logic       busy, done, zf, cf, nf, vf;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  alu_seq #(.DATA_WIDTH(8), .ENABLE_MUL(1'b1)) dut (
    .i_CLOCK(clock), .i_CLEAR_N(clear_n), .i_A_DATA(a_data), .i_B_DATA(b_data),
    .i_OP(op), .i_START(start), .i_UPDATE_FLAGS(update_flags), .i_WRITE_BUS(write_bus),
    .o_BUS(bus), .o_RESULT_HI(result_hi), .o_BUSY(busy), .o_DONE(done),
    .o_ZERO_FLAG(zf), .o_CARRY_FLAG(cf), .o_NEGATIVE_FLAG(nf), .o_OVERFLOW_FLAG(vf)
  );

  typedef struct {
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       upd;
    logic [7:0] lo;
    logic [7:0] hi;
    logic [3:0] flags;  // {Z, C, N, V}
    int         lat;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Issue one op, scramble inputs after the START edge, wait (bounded) for DONE.
  task automatic applyStimulus(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                               input logic u, output int lat, output int busy_cycles);
    @(negedge clock);
    op = o; a_data = a; b_data = b; update_flags = u; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    a_data = 8'($urandom); b_data = 8'($urandom);
    op = 4'($urandom); update_flags = 1'($urandom);
    lat = 1;
    busy_cycles = 0;
    while (!done && lat < 40) begin
      if (busy) busy_cycles++;
      @(negedge clock);
      lat++;
    end
  endtask

  initial begin
    int lat, bcyc, done_seen;

    vecs[0]  = '{4'd0,  8'hF0, 8'h20, 1'b1, 8'h10, 8'h00, 4'b0100, 1};
    vecs[1]  = '{4'd1,  8'h05, 8'h05, 1'b1, 8'h00, 8'h00, 4'b1000, 1};
    vecs[2]  = '{4'd1,  8'h03, 8'h05, 1'b1, 8'hFE, 8'h00, 4'b0110, 1};
    vecs[3]  = '{4'd3,  8'h10, 8'h01, 1'b1, 8'h0E, 8'h00, 4'b0000, 1};
    vecs[4]  = '{4'd0,  8'h7F, 8'h01, 1'b1, 8'h80, 8'h00, 4'b0011, 1};
    vecs[5]  = '{4'd4,  8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 4'b0011, 1};
    vecs[6]  = '{4'd0,  8'hFF, 8'h01, 1'b1, 8'h00, 8'h00, 4'b1100, 1};
    vecs[7]  = '{4'd2,  8'h10, 8'h20, 1'b1, 8'h31, 8'h00, 4'b0000, 1};
    vecs[8]  = '{4'd5,  8'h0F, 8'h30, 1'b1, 8'h3F, 8'h00, 4'b0000, 1};
    vecs[9]  = '{4'd6,  8'hAA, 8'hAA, 1'b1, 8'h00, 8'h00, 4'b1000, 1};
    vecs[10] = '{4'd7,  8'h0F, 8'h00, 1'b1, 8'hF0, 8'h00, 4'b0010, 1};
    vecs[11] = '{4'd8,  8'h81, 8'h03, 1'b1, 8'h08, 8'h00, 4'b0000, 4};
    vecs[12] = '{4'd10, 8'h80, 8'h02, 1'b1, 8'hE0, 8'h00, 4'b0010, 3};
    vecs[13] = '{4'd9,  8'h03, 8'h01, 1'b1, 8'h01, 8'h00, 4'b0100, 2};
    vecs[14] = '{4'd8,  8'h55, 8'h00, 1'b1, 8'h55, 8'h00, 4'b0000, 1};
    vecs[15] = '{4'd9,  8'h80, 8'h09, 1'b1, 8'h40, 8'h00, 4'b0000, 2};
    vecs[16] = '{4'd11, 8'h10, 8'h20, 1'b1, 8'h00, 8'h02, 4'b0101, 9};
    vecs[17] = '{4'd11, 8'hFF, 8'hFF, 1'b1, 8'h01, 8'hFE, 4'b0111, 9};
    vecs[18] = '{4'd12, 8'h12, 8'h34, 1'b1, 8'h00, 8'h00, 4'b1000, 1};
    vecs[19] = '{4'd11, 8'h03, 8'h05, 1'b1, 8'h0F, 8'h00, 4'b0000, 9};
    vecs[20] = '{4'd10, 8'h7F, 8'h07, 1'b1, 8'h00, 8'h00, 4'b1100, 8};

    clear_n = 1'b0; start = 1'b0; op = '0; a_data = '0; b_data = '0;
    update_flags = 1'b0; write_bus = 1'b1;
    repeat (2) @(negedge clock);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_done", done, 0);
    checkOutput("reset_bus", bus, 8'h00);
    checkOutput("reset_hi", result_hi, 8'h00);
    checkOutput("reset_flags", {zf, cf, nf, vf}, 4'b0000);
    clear_n = 1'b1;

    for (int i = 0; i < NV; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].upd, lat, bcyc);
      checkOutput($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      checkOutput($sformatf("v%0d_busy_cycles", i), bcyc, vecs[i].lat - 1);
      checkOutput($sformatf("v%0d_bus", i), bus, vecs[i].lo);
      checkOutput($sformatf("v%0d_hi", i), result_hi, vecs[i].hi);
      checkOutput($sformatf("v%0d_flags", i), {zf, cf, nf, vf}, vecs[i].flags);
    end

    // Bus release
    applyStimulus(4'd0, 8'hF0, 8'h20, 1'b1, lat, bcyc);
    write_bus = 1'b0;
    #1;
    checkOutput("bus_released", (bus === 8'h10), 0);
    write_bus = 1'b1;
    #1;
    checkOutput("bus_redriven", bus, 8'h10);

    // START mid-shift is ignored
    @(negedge clock);
    op = 4'd8; a_data = 8'h81; b_data = 8'h03; update_flags = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("midshift_busy_c1", busy, 1);
    checkOutput("midshift_bus_prev", bus, 8'h10);
    @(negedge clock);
    op = 4'd0; a_data = 8'h01; b_data = 8'h01; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("midshift_busy_c3", busy, 1);
    checkOutput("midshift_done_c3", done, 0);
    @(negedge clock);
    checkOutput("midshift_done_c4", done, 1);
    checkOutput("midshift_bus_c4", bus, 8'h08);
    @(negedge clock);
    checkOutput("midshift_no_extra_done", done, 0);
    checkOutput("midshift_idle", busy, 0);
    checkOutput("midshift_bus_kept", bus, 8'h08);

    // START in the DONE cycle of a shift is accepted
    applyStimulus(4'd9, 8'h04, 8'h01, 1'b1, lat, bcyc);
    checkOutput("b2b_shift_latency", lat, 2);
    checkOutput("b2b_shift_bus", bus, 8'h02);
    op = 4'd0; a_data = 8'h01; b_data = 8'h02; update_flags = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    checkOutput("b2b_add_done", done, 1);
    checkOutput("b2b_add_bus", bus, 8'h03);

    // Reset aborts an in-flight MUL
    applyStimulus(4'd0, 8'h7F, 8'h01, 1'b1, lat, bcyc);
    checkOutput("pre_reset_flags", {zf, cf, nf, vf}, 4'b0011);
    @(negedge clock);
    op = 4'd11; a_data = 8'h10; b_data = 8'h20; update_flags = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(negedge clock);
    checkOutput("mul_busy_before_reset", busy, 1);
    clear_n = 1'b0;
    @(negedge clock);
    checkOutput("abort_busy", busy, 0);
    checkOutput("abort_done", done, 0);
    checkOutput("abort_bus", bus, 8'h00);
    checkOutput("abort_hi", result_hi, 8'h00);
    checkOutput("abort_flags", {zf, cf, nf, vf}, 4'b0000);
    clear_n = 1'b1;
    done_seen = 0;
    repeat (12) begin
      @(negedge clock);
      if (done) done_seen++;
    end
    checkOutput("abort_no_done", done_seen, 0);

    // Reserved opcode after reset
    applyStimulus(4'd13, 8'hAB, 8'hCD, 1'b1, lat, bcyc);
    checkOutput("rsv_latency", lat, 1);
    checkOutput("rsv_bus", bus, 8'h00);
    checkOutput("rsv_flags", {zf, cf, nf, vf}, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
